// File: rtl/control_sequencer.sv
// Microcoded control sequencer for an 8-bit breadboard-style CPU: steps through
// fetch/execute T-states and decodes the 16-bit control word each cycle.
module control_sequencer (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [3:0]  OPCODE,
    input  logic        CF,
    input  logic        ZF,
    output logic [2:0]  STEP,
    output logic [15:0] CTRL
);

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'he,
        OP_HLT = 4'hf
    } opcode_e;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    step_e   step_q, step_d;
    logic    halted_q, halted_d;
    step_e   last_step;
    opcode_e op;

    assign op   = opcode_e'(OPCODE);
    assign STEP = step_q;

    always_comb begin
        last_step = T2;
        case (op)
            OP_ADD, OP_SUB: last_step = T4;
            OP_LDA, OP_STA: last_step = T3;
            default:        last_step = T2;
        endcase
    end

    // Fetch steps never consult OPCODE, so IR loading during T1 cannot disturb sequencing.
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            case (step_q)
                T0: step_d = T1;
                T1: step_d = T2;
                T2: begin
                    if (op == OP_HLT)
                        halted_d = 1'b1;
                    else
                        step_d = (last_step == T2) ? T0 : T3;
                end
                T3:      step_d = (last_step == T4) ? T4 : T0;
                T4:      step_d = T0;
                default: step_d = T0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        CTRL = 16'h0000;
        if (halted_q) begin
            CTRL = C_HLT;
        end else begin
            case (step_q)
                T0: CTRL = C_CO | C_MI;
                T1: CTRL = C_RO | C_II | C_CE;
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: CTRL = C_IO | C_MI;
                        OP_LDI: CTRL = C_IO | C_AI;
                        OP_JMP: CTRL = C_IO | C_J;
                        OP_JC:  CTRL = CF ? (C_IO | C_J) : 16'h0000;
                        OP_JZ:  CTRL = ZF ? (C_IO | C_J) : 16'h0000;
                        OP_OUT: CTRL = C_AO | C_OI;
                        OP_HLT: CTRL = C_HLT;
                        default: CTRL = 16'h0000;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA:         CTRL = C_RO | C_AI;
                        OP_ADD, OP_SUB: CTRL = C_RO | C_BI;
                        OP_STA:         CTRL = C_AO | C_RI;
                        default:        CTRL = 16'h0000;
                    endcase
                end
                T4: begin
                    case (op)
                        OP_ADD:  CTRL = C_EO | C_AI | C_FI;
                        OP_SUB:  CTRL = C_EO | C_AI | C_SU | C_FI;
                        default: CTRL = 16'h0000;
                    endcase
                end
                default: CTRL = 16'h0000;
            endcase
        end
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters: none; the step width is fixed at 3 bits and the control word at 16 bits.
REQ-002 CLK  input  1  single system clock; all state updates on the rising edge.
REQ-003 CLR  input  1  reset, synchronous, active-high.
REQ-004 OPCODE  input  4  upper nibble of the instruction register; valid from step 2 onward.
REQ-005 CF  input  1  registered carry flag from the ALU flag register.
REQ-006 ZF  input  1  registered zero flag from the ALU flag register.
REQ-007 STEP  output  3  current micro-step (T-state), registered.
REQ-008 CTRL  output  16  active-high control word; bit map: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
REQ-009 CTRL SHALL be decoded combinationally from STEP, the internal halted bit, OPCODE, CF and ZF; polarity inversion for active-low consumers (EO, FI) is done at top-level integration.

Function
REQ-010 Fetch: step 0 SHALL emit CO|MI (0x4004); step 1 SHALL emit RO|II|CE (0x1408), independent of OPCODE.
REQ-011 Execute words (step 2/3/4): LDA 0001 = IO|MI / RO|AI; ADD 0010 = IO|MI / RO|BI / EO|AI|FI; SUB 0011 = IO|MI / RO|BI / EO|AI|SU|FI.
REQ-012 Execute words, continued: STA 0100 = IO|MI / AO|RI; LDI 0101 = IO|AI; JMP 0110 = IO|J; OUT 1110 = AO|OI; HLT 1111 = HLT.
REQ-013 JC 0111 SHALL emit IO|J at step 2 when CF=1, else 0x0000; JZ 1000 likewise with ZF.
REQ-014 NOP 0000 and undefined opcodes (1001-1101) SHALL emit 0x0000 at step 2.
REQ-015 Last step per opcode: ADD/SUB = 4; LDA/STA = 3; all others = 2.
REQ-016 STEP SHALL increment by 1 each clock and return to 0 on the edge ending the opcode's last step; no instruction SHALL occupy more than 5 cycles.
REQ-017 JC/JZ length SHALL be 3 cycles (last step 2) regardless of flag value.
REQ-018 CF/ZF SHALL be used only during step 2 of JC/JZ; flag changes at other times SHALL have no effect.
REQ-019 OPCODE changes during steps 0-1 SHALL NOT affect CTRL or STEP sequencing.
REQ-020 HLT: on the edge ending step 2 of HLT, the halted bit SHALL set; STEP SHALL hold at 2.
REQ-021 While halted: CTRL SHALL be 0x8000, and OPCODE, CF and ZF SHALL be ignored.
REQ-022 The halted state SHALL be left only via CLR.
REQ-023 Exactly one micro-step SHALL be emitted per clock; no step value 5-7 SHALL ever be reachable.

Reset
REQ-024 CLR=1 at a rising edge SHALL force STEP=0 and clear the halted bit, so that CTRL=0x4004 the next cycle.
REQ-025 CLR SHALL take priority over increment, wrap and halt, at any step and in any state, including mid-instruction and while halted.
REQ-026 Before the first CLR, state is undefined; the bench SHALL apply CLR for at least 1 cycle before checking.

Verification
REQ-027 Reset then OPCODE=0011, run 5 cycles -> CTRL sequence 0x4004, 0x1408, 0x4800, 0x1020, 0x02C1; STEP then returns to 0.
REQ-028 OPCODE=0111 with CF=0 -> step-2 CTRL=0x0000; repeat with CF=1 -> 0x0802; both cases return to STEP=0 after step 2.
REQ-029 OPCODE=0101 -> step 2 CTRL=0x0A00, next cycle STEP=0/CTRL=0x4004; OPCODE=0100 -> steps 2-3 = 0x4800, 0x2100, then STEP=0.
REQ-030 OPCODE=1111 -> step 2 CTRL=0x8000; for 10 further cycles with OPCODE and flags toggling, CTRL=0x8000 and STEP=2; CLR -> 0x4004.
REQ-031 CLR asserted at step 3 of ADD -> next cycle STEP=0, CTRL=0x4004, no EO/AI/FI emitted.
REQ-032 Undefined OPCODE=1010 -> step 2 CTRL=0x0000, then STEP=0; a 1000-instruction random opcode stream SHALL never show STEP>4.
